// File: rtl/trng_fifo_pkg.sv
// Shared constants, flag bundle and elaboration-time helpers for the TRNG sample FIFO.
package trng_fifo_pkg;

  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_DEPTH  = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Flag state of a FIFO holding nothing; thresholds are constrained so this is exact.
  localparam fifo_flags_t FLAGS_RESET = '{
    full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1
  };

  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int data_w, input int depth,
                                      input int afull_th, input int aempty_th);
    return (data_w >= 1) && (depth >= 4) && is_pow2(depth) &&
           (aempty_th >= 0) && (aempty_th < afull_th) && (afull_th <= depth);
  endfunction

endpackage

// File: rtl/trng_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port with enable.
module trng_fifo_ram
  import trng_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AW     = log2_ceil(DEFAULT_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: neither the array nor the read register is reset, so the pair maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trng_fifo_sync.sv
// Single-clock TRNG sample FIFO with optional first-word-fall-through, occupancy,
// threshold flags, sticky error flags and synchronous flush.
module trng_fifo_sync
  import trng_fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter bit FWFT      = 1'b0,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        din,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [log2_ceil(DEPTH):0] count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int AW = log2_ceil(DEPTH);
  localparam int CW = AW + 1;

  if (!params_legal(DATA_W, DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $error("trng_fifo_sync: DEPTH must be a power of two >= 4 and AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [AW-1:0]     w_ptr, r_ptr;
  logic [CW-1:0]     mem_cnt;
  logic              head_valid;
  logic              dout_zero;
  logic [DATA_W-1:0] ram_rdata;
  fifo_flags_t       flags_q, flags_d;

  logic              wr_acc, rd_acc, load, head_valid_nxt;
  logic [CW-1:0]     count_nxt, mem_cnt_nxt;

  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;

  // The read register keeps its last word; dout_zero masks it after reset or flush.
  assign dout = dout_zero ? '0 : ram_rdata;

  always_comb begin
    // NOTE: every signal driven here is assigned on all paths, so no latch is inferred.
    wr_acc         = wr_en && !flags_q.full && !flush;
    rd_acc         = rd_en && !flags_q.empty && !flush;
    load           = 1'b0;
    head_valid_nxt = 1'b0;
    if (FWFT) begin
      // Prefetch into the empty head slot, or refill it on the same edge it is popped.
      load           = (mem_cnt != '0) && (!head_valid || rd_acc) && !flush;
      head_valid_nxt = load || (head_valid && !rd_acc);
    end else begin
      load = rd_acc;
    end
    count_nxt   = count + CW'(wr_acc) - CW'(rd_acc);
    mem_cnt_nxt = mem_cnt + CW'(wr_acc) - CW'(load);

    flags_d.full         = (count_nxt == CW'(DEPTH));
    flags_d.empty        = FWFT ? !head_valid_nxt : (count_nxt == '0);
    flags_d.almost_full  = (int'(count_nxt) >= AFULL_TH);
    flags_d.almost_empty = (int'(count_nxt) <= AEMPTY_TH);
  end

  trng_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (w_ptr),
    .wdata (din),
    .re    (load),
    .raddr (r_ptr),
    .rdata (ram_rdata)
  );

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr      <= '0;
      r_ptr      <= '0;
      count      <= '0;
      mem_cnt    <= '0;
      head_valid <= 1'b0;
      dout_zero  <= 1'b1;
      dout_valid <= 1'b0;
      flags_q    <= FLAGS_RESET;
    end else if (flush) begin
      w_ptr      <= '0;
      r_ptr      <= '0;
      count      <= '0;
      mem_cnt    <= '0;
      head_valid <= 1'b0;
      dout_zero  <= 1'b1;
      dout_valid <= 1'b0;
      flags_q    <= FLAGS_RESET;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + AW'(1);
      if (load) begin
        r_ptr     <= r_ptr + AW'(1);
        dout_zero <= 1'b0;
      end
      count      <= count_nxt;
      mem_cnt    <= mem_cnt_nxt;
      head_valid <= head_valid_nxt;
      dout_valid <= FWFT ? head_valid_nxt : rd_acc;
      flags_q    <= flags_d;
    end
  end

  // A read that coincides with a write into an empty FIFO is rejected but not an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en && flags_q.full && !flush) || (overflow && !clr_err);
      underflow <= (rd_en && !wr_en && flags_q.empty && !flush) || (underflow && !clr_err);
    end
  end

endmodule

// File: doc/trng_fifo_sync.md
Name: trng_fifo_sync

Overview:
- Parametrised single-clock FIFO; next generation of the 64-bit TRNG sample buffer.
- Sits between the ring-oscillator sampler/conditioner (writer) and the AXI/readout logic (reader).
- Adds over the fixed-width buffer: configurable width and depth, optional first-word-fall-through (FWFT), occupancy output, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, synchronous flush.

Parameters:
- DATA_W, 64: data width in bits, ≥1.
- DEPTH, 16: word capacity; power of two, ≥4.
- FWFT, 0: 0 = standard read (1-cycle latency); 1 = first-word-fall-through.
- AFULL_TH, DEPTH-2: almost_full asserted when count ≥ AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserted when count ≤ AEMPTY_TH.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- din  in  DATA_W  write data.
- rd_en  in  1  read request (standard) / pop head (FWFT).
- dout  out  DATA_W  read data.
- dout_valid  out  1  standard mode: high one cycle after an accepted read; FWFT: equals !empty.
- full  out  1  count == DEPTH.
- empty  out  1  no word readable.
- almost_full  out  1  count ≥ AFULL_TH.
- almost_empty  out  1  count ≤ AEMPTY_TH.
- count  out  $clog2(DEPTH)+1  words held, including the FWFT output register.
- overflow  out  1  sticky: wr_en while full.
- underflow  out  1  sticky: rd_en while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (async, any time, including mid-transfer): pointers = 0, count = 0, dout = 0, dout_valid = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = underflow = 0. Memory contents are not cleared.
- Write accept: wr_en && !full. A write is rejected whenever full, even if a read occurs in the same cycle.
- Read accept: rd_en && !empty. When empty with wr_en && rd_en together, the write is accepted and the read is rejected.
- Pointers wrap from DEPTH-1 to 0. count rules:
  - Write-only accept: +1.
  - Read-only accept: −1.
  - Both accepted, or neither: unchanged.
- Standard mode:
  - Accepted read at edge N: dout = mem[r_ptr] and dout_valid = 1 after edge N. dout_valid returns to 0 after the next edge with no accepted read.
  - dout holds its last value otherwise.
  - A write at edge N clears empty after edge N.
- FWFT mode:
  - An output register holds the head word; dout = head whenever !empty.
  - The output register is refilled from memory on the same edge it is popped, if memory is non-empty.
  - Write into a completely empty FIFO at edge N: word lands in memory at N and is prefetched at N+1. empty falls and dout is valid after edge N+1.
  - count includes the output register; full is based on total count.
- Flags are registered, updated on the same edge as count.
- Flush:
  - Highest priority over wr_en/rd_en in the same cycle.
  - Next edge: pointers = 0, count = 0, dout = 0, dout_valid = 0, empty = 1.
  - Error flags are unaffected.
- Error flags:
  - overflow sets on wr_en && full; underflow sets on rd_en && empty. Both are sticky.
  - clr_err clears them; if a set condition and clr_err occur in the same cycle, set wins.
  - Rejected operations never change memory or pointers.

Decomposition:
- Package trng_fifo_pkg holds:
  - Default DATA_W/DEPTH constants.
  - A log2 helper function.
  - Parameter-legality checks (DEPTH power of two; AEMPTY_TH < AFULL_TH ≤ DEPTH).
- One sub-module, trng_fifo_ram: simple dual-port memory, one write port, one registered read port, block-RAM inferable.
- Top level holds pointers, count, flags and the FWFT output register.

Test Plan:
- Standard, DEPTH=16: write 0x1..0x10, then 17th write → full=1, overflow=1, count=16. Read 16 → dout 0x1..0x10 in order, each one cycle after rd_en, empty=1 after last.
- Wrap: write 12, read 12, write 8, read 8 → order preserved across pointer wrap, count returns to 0.
- Simultaneous, count=5: wr_en && rd_en for 10 cycles → count stays 5, output order correct. Repeat when empty → count becomes 1, underflow=0 (read rejected, not flagged, since the write is accepted). rd_en alone while empty → underflow=1.
- FWFT=1: single write 0xA5A5 at edge N → empty=0 and dout=0xA5A5 after edge N+1. rd_en → empty=1 next cycle.
- Thresholds AFULL_TH=14, AEMPTY_TH=2: fill 0→16 → almost_empty drops at count 3, almost_full rises at count 14.
- Flush with count=9 plus concurrent wr_en → count=0, empty=1, write discarded. Async rst mid-burst → all outputs at reset values immediately, without waiting for a clock edge.
